// File: rtl/pwm_pkg.sv
// Shared constants and types for the PWM block: default sizes, register map
// addresses and the counter value type.
package pwm_pkg;

    localparam int CW       = 16;
    localparam int CHANNELS = 4;
    localparam int ADDR_W   = 3;

    localparam logic [ADDR_W-1:0] ADDR_PERIOD = 3'd0;
    localparam logic [ADDR_W-1:0] ADDR_CTRL   = 3'd1;
    localparam logic [ADDR_W-1:0] ADDR_DUTY0  = 3'd2;

    // Counter, period and duty values all share this width.
    typedef logic [CW-1:0] cnt_t;

endpackage

// File: rtl/pwm_if.sv
// Bundle of every PWM signal. clk/resetn come in as ports; everything else is
// a member. resetn is active-high despite its name (1 = reset asserted).
//
// Read handshake: rd_en is a one-cycle request with no back-pressure; the
// block answers exactly one cycle later with rd_valid=1 for one cycle, and
// rd_data is meaningful only while rd_valid is 1.
interface pwm_if #(
    parameter int CHANNELS = pwm_pkg::CHANNELS,
    parameter int CW       = pwm_pkg::CW
) (
    input logic clk,
    input logic resetn
);

    logic                wr_en;
    logic [2:0]          addr;
    logic [CW-1:0]       wr_data;
    logic                rd_en;
    logic [CW-1:0]       rd_data;
    logic                rd_valid;
    logic [CHANNELS-1:0] pwm_out;
    logic                period_tick;

    modport dut (
        input  clk, resetn, wr_en, addr, wr_data, rd_en,
        output rd_data, rd_valid, pwm_out, period_tick
    );

    modport tb (
        input  clk, resetn, rd_data, rd_valid, pwm_out, period_tick,
        output wr_en, addr, wr_data, rd_en
    );

endinterface

// File: rtl/pwm_regs.sv
// Programmed register file (PERIOD, CTRL, DUTY[i]) and the registered read
// path. Reads see the value before any same-cycle write to that address.
module pwm_regs #(
    parameter int CHANNELS = pwm_pkg::CHANNELS,
    parameter int CW       = pwm_pkg::CW
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   wr_en,
    input  logic [2:0]             addr,
    input  logic [CW-1:0]          wr_data,
    input  logic                   rd_en,
    output logic [CW-1:0]          rd_data,
    output logic                   rd_valid,
    output logic [CW-1:0]          period,
    output logic                   enable,
    output logic [CHANNELS*CW-1:0] duty_flat
);

    import pwm_pkg::*;

    logic [CW-1:0]                period_q, period_d;
    logic                         enable_q, enable_d;
    logic [CHANNELS-1:0][CW-1:0]  duty_q, duty_d;
    logic [CW-1:0]                rd_data_q, rd_data_d;
    logic                         rd_valid_q, rd_valid_d;
    logic [CW-1:0]                rd_mux;
    logic                         duty_hit;
    logic [2:0]                   duty_off;

    // DUTY window decode: addresses ADDR_DUTY0 .. ADDR_DUTY0+CHANNELS-1.
    assign duty_hit = (int'(addr) >= int'(ADDR_DUTY0)) &&
                      (int'(addr) <  int'(ADDR_DUTY0) + CHANNELS);
    assign duty_off = addr - ADDR_DUTY0;

    // Read mux over the programmed (pre-write) register values.
    always_comb begin
        rd_mux = '0;
        if (addr == ADDR_PERIOD) begin
            rd_mux = period_q;
        end else if (addr == ADDR_CTRL) begin
            rd_mux = {{(CW-1){1'b0}}, enable_q};
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (duty_hit && (duty_off == 3'(i))) begin
                    rd_mux = duty_q[i];
                end
            end
        end
    end

    // Next-state for the register file and read response.
    always_comb begin
        period_d   = period_q;
        enable_d   = enable_q;
        duty_d     = duty_q;
        rd_valid_d = rd_en;
        rd_data_d  = rd_en ? rd_mux : '0;
        if (wr_en) begin
            if (addr == ADDR_PERIOD) begin
                period_d = wr_data;
            end else if (addr == ADDR_CTRL) begin
                enable_d = wr_data[0];
            end else begin
                for (int i = 0; i < CHANNELS; i++) begin
                    if (duty_hit && (duty_off == 3'(i))) begin
                        duty_d[i] = wr_data;
                    end
                end
            end
        end
    end

    // Register file and read response flops, cleared asynchronously.
    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            period_q   <= '0;
            enable_q   <= 1'b0;
            duty_q     <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            period_q   <= period_d;
            enable_q   <= enable_d;
            duty_q     <= duty_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;
    assign period    = period_q;
    assign enable    = enable_q;
    assign duty_flat = duty_q;

endmodule

// File: rtl/pwm.sv
// Multi-channel PWM: free-running counter with shadowed period/duty values
// that reload only at a period wrap, so software writes never glitch the
// waveform in flight. Outputs are registered (one-cycle latency).
module pwm #(
    parameter int CHANNELS = pwm_pkg::CHANNELS,
    parameter int CW       = pwm_pkg::CW
) (
    pwm_if.dut interf
);

    import pwm_pkg::*;

    logic [CW-1:0]                period;
    logic                         enable;
    logic [CHANNELS*CW-1:0]       duty_flat;

    logic [CW-1:0]                cnt_q, cnt_d;
    logic [CW-1:0]                period_sh_q, period_sh_d;
    logic [CHANNELS-1:0][CW-1:0]  duty_sh_q, duty_sh_d;
    logic [CHANNELS-1:0]          pwm_out_q, pwm_out_d;
    logic                         tick_q, tick_d;
    logic                         running;
    logic                         wrap;

    pwm_regs #(
        .CHANNELS (CHANNELS),
        .CW       (CW)
    ) u_regs (
        .clk       (interf.clk),
        .resetn    (interf.resetn),
        .wr_en     (interf.wr_en),
        .addr      (interf.addr),
        .wr_data   (interf.wr_data),
        .rd_en     (interf.rd_en),
        .rd_data   (interf.rd_data),
        .rd_valid  (interf.rd_valid),
        .period    (period),
        .enable    (enable),
        .duty_flat (duty_flat)
    );

    // A zero shadow period parks the counter exactly like ENABLE=0 does.
    assign running = enable && (period_sh_q != '0);
    // cnt never exceeds period_sh-1, so this is the last count of a period.
    assign wrap    = running && (cnt_q == period_sh_q - CW'(1));

    // Counter, shadow reload and comparator next-state.
    always_comb begin
        cnt_d       = cnt_q;
        period_sh_d = period_sh_q;
        duty_sh_d   = duty_sh_q;
        pwm_out_d   = '0;
        tick_d      = 1'b0;
        if (!running) begin
            // Idle: hold count at 0 and keep shadows tracking the registers,
            // so the first period after start uses current programming.
            cnt_d       = '0;
            period_sh_d = period;
            duty_sh_d   = duty_flat;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                pwm_out_d[i] = (cnt_q < duty_sh_q[i]);
            end
            if (wrap) begin
                cnt_d       = '0;
                tick_d      = 1'b1;
                period_sh_d = period;
                duty_sh_d   = duty_flat;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    // Counter, shadows and registered outputs, cleared asynchronously.
    always_ff @(posedge interf.clk or posedge interf.resetn) begin
        if (interf.resetn) begin
            cnt_q       <= '0;
            period_sh_q <= '0;
            duty_sh_q   <= '0;
            pwm_out_q   <= '0;
            tick_q      <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            period_sh_q <= period_sh_d;
            duty_sh_q   <= duty_sh_d;
            pwm_out_q   <= pwm_out_d;
            tick_q      <= tick_d;
        end
    end

    assign interf.pwm_out     = pwm_out_q;
    assign interf.period_tick = tick_q;

endmodule

// File: tb/tb_pwm.sv
// Bench for pwm: directed scenarios plus randomized register traffic, every
// cycle compared against a behavioural model of the programmed/shadow
// registers and the period counter.
module tb_pwm;

    import pwm_pkg::*;

    localparam int CH = CHANNELS;

    logic clk;
    logic resetn;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    pwm_if intf (.clk(clk), .resetn(resetn));

    pwm dut (.interf(intf));

    int tests_run    = 0;
    int tests_failed = 0;

    // Behavioural model state
    int unsigned   m_period, m_en, m_psh, m_cnt;
    int unsigned   m_duty [CH];
    int unsigned   m_dsh  [CH];
    logic [CH-1:0] m_out;
    logic          m_tick;
    logic          m_rd_valid;
    logic [CW-1:0] m_rd_data;

    // Observed-activity counters for window checks
    int obs_hi [CH];
    int obs_ticks;

    function automatic int unsigned model_read(input int unsigned a);
        if (a == 0) return m_period;
        if (a == 1) return m_en;
        if (a >= 2 && a < 2 + CH) return m_duty[a-2];
        return 0;
    endfunction

    task automatic model_reset();
        m_period = 0; m_en = 0; m_psh = 0; m_cnt = 0;
        for (int i = 0; i < CH; i++) begin
            m_duty[i] = 0;
            m_dsh[i]  = 0;
        end
        m_out = '0; m_tick = 1'b0; m_rd_valid = 1'b0; m_rd_data = '0;
    endtask

    // One clock edge of the specified behaviour, using inputs held at the edge.
    task automatic model_edge();
        bit run;
        bit last;
        if (resetn) begin
            model_reset();
            return;
        end
        run  = (m_en != 0) && (m_psh != 0);
        last = run && (m_cnt + 32'd1 == m_psh);
        m_rd_valid = intf.rd_en;
        m_rd_data  = intf.rd_en ? CW'(model_read(32'(intf.addr))) : '0;
        for (int i = 0; i < CH; i++) m_out[i] = run && (m_cnt < m_dsh[i]);
        m_tick = last;
        if (!run || last) begin
            m_cnt = 0;
            m_psh = m_period;
            for (int i = 0; i < CH; i++) m_dsh[i] = m_duty[i];
        end else begin
            m_cnt = m_cnt + 32'd1;
        end
        if (intf.wr_en) begin
            if (intf.addr == 3'd0) m_period = 32'(intf.wr_data);
            else if (intf.addr == 3'd1) m_en = 32'(intf.wr_data[0]);
            else if (32'(intf.addr) < 2 + CH) m_duty[32'(intf.addr) - 2] = 32'(intf.wr_data);
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_obs();
        for (int i = 0; i < CH; i++) obs_hi[i] = 0;
        obs_ticks = 0;
    endtask

    // Advance one clock, update the model, compare all outputs, drop strobes.
    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check({tag, ".pwm_out"}, 32'(intf.pwm_out), 32'(m_out));
        check({tag, ".tick"}, 32'(intf.period_tick), 32'(m_tick));
        check({tag, ".rd_valid"}, 32'(intf.rd_valid), 32'(m_rd_valid));
        if (m_rd_valid) check({tag, ".rd_data"}, 32'(intf.rd_data), 32'(m_rd_data));
        for (int i = 0; i < CH; i++) obs_hi[i] += int'(intf.pwm_out[i]);
        obs_ticks += int'(intf.period_tick);
        intf.wr_en = 1'b0;
        intf.rd_en = 1'b0;
    endtask

    task automatic write_reg(input int a, input int unsigned d, input string tag);
        intf.wr_en   = 1'b1;
        intf.addr    = 3'(a);
        intf.wr_data = CW'(d);
        step(tag);
    endtask

    task automatic read_reg(input int a, input string tag);
        intf.rd_en = 1'b1;
        intf.addr  = 3'(a);
        step(tag);
    endtask

    // Step until period_tick is seen; an expired budget is a failure.
    task automatic wait_tick(input string tag, output int waited);
        waited = 0;
        for (int k = 0; k < 64; k++) begin
            step(tag);
            waited++;
            if (intf.period_tick) return;
        end
        check({tag, ".tick_timeout"}, 32'(intf.period_tick), 32'd1);
    endtask

    initial begin
        int waited;
        intf.wr_en = 1'b0; intf.rd_en = 1'b0; intf.addr = '0; intf.wr_data = '0;
        resetn = 1'b1;
        model_reset();
        clear_obs();

        // Reset state
        #12;
        check("reset.pwm_out", 32'(intf.pwm_out), 32'd0);
        check("reset.tick", 32'(intf.period_tick), 32'd0);
        check("reset.rd_valid", 32'(intf.rd_valid), 32'd0);
        check("reset.rd_data", 32'(intf.rd_data), 32'd0);
        resetn = 1'b0;

        // Idle after reset; all registers read 0
        repeat (5) step("idle");
        for (int a = 0; a < 8; a++) begin
            read_reg(a, "rd_reset");
            check("rd_reset.value", 32'(intf.rd_data), 32'd0);
        end

        // PERIOD=10, DUTY0=3, DUTY1=0, DUTY2=10, DUTY3=5, ENABLE=1
        write_reg(0, 10, "cfg");
        write_reg(2, 3, "cfg");
        write_reg(3, 0, "cfg");
        write_reg(4, 10, "cfg");
        write_reg(5, 5, "cfg");
        write_reg(1, 1, "cfg");
        read_reg(0, "rd_period");
        check("rd_period.value", 32'(intf.rd_data), 32'd10);
        read_reg(1, "rd_ctrl");
        check("rd_ctrl.value", 32'(intf.rd_data), 32'd1);

        wait_tick("align", waited);
        clear_obs();
        repeat (30) step("run10");
        check("run10.hi0", 32'(obs_hi[0]), 32'd9);
        check("run10.hi1_const_low", 32'(obs_hi[1]), 32'd0);
        check("run10.hi2_const_high", 32'(obs_hi[2]), 32'd30);
        check("run10.ticks", 32'(obs_ticks), 32'd3);

        // Mid-period DUTY0 write at cnt=5 affects only the next period
        clear_obs();
        for (int k = 0; k < 10; k++) begin
            if (k == 5) write_reg(2, 7, "midwr");
            else step("midwr");
        end
        check("midwr.cur_hi0", 32'(obs_hi[0]), 32'd3);
        check("midwr.cur_ticks", 32'(obs_ticks), 32'd1);
        clear_obs();
        repeat (10) step("midwr_next");
        check("midwr.next_hi0", 32'(obs_hi[0]), 32'd7);

        // Clear ENABLE at cnt=2, then restart
        repeat (2) step("dis");
        write_reg(1, 0, "dis");
        step("dis_edge");
        check("dis.pwm_out_low", 32'(intf.pwm_out), 32'd0);
        clear_obs();
        repeat (8) step("dis_hold");
        check("dis.ticks", 32'(obs_ticks), 32'd0);
        check("dis.hi2", 32'(obs_hi[2]), 32'd0);
        read_reg(1, "dis_rd");
        check("dis_rd.value", 32'(intf.rd_data), 32'd0);
        write_reg(1, 1, "reen");
        wait_tick("reen", waited);
        check("reen.first_tick_cycles", 32'(waited), 32'd10);

        // Reset mid-period: outputs drop at once
        repeat (4) step("pre_rst");
        #2;
        resetn = 1'b1;
        #1;
        check("rst_mid.pwm_out", 32'(intf.pwm_out), 32'd0);
        check("rst_mid.tick", 32'(intf.period_tick), 32'd0);
        check("rst_mid.rd_valid", 32'(intf.rd_valid), 32'd0);
        model_reset();
        step("in_rst");
        #2;
        resetn = 1'b0;
        read_reg(0, "rst_rd");
        check("rst_rd.valid", 32'(intf.rd_valid), 32'd1);
        check("rst_rd.period", 32'(intf.rd_data), 32'd0);
        step("rst_rd_after");
        clear_obs();
        repeat (20) step("post_rst_idle");
        check("post_rst.ticks", 32'(obs_ticks), 32'd0);
        check("post_rst.hi0", 32'(obs_hi[0]), 32'd0);

        // PERIOD=0 with ENABLE=1, then PERIOD=4
        write_reg(2, 2, "p0");
        write_reg(1, 1, "p0");
        clear_obs();
        repeat (10) step("p0_run");
        check("p0.ticks", 32'(obs_ticks), 32'd0);
        check("p0.hi0", 32'(obs_hi[0]), 32'd0);
        write_reg(0, 4, "p4");
        wait_tick("p4", waited);
        clear_obs();
        repeat (12) step("p4_run");
        check("p4.ticks", 32'(obs_ticks), 32'd3);
        check("p4.hi0", 32'(obs_hi[0]), 32'd6);

        // Same-cycle write and read of one address returns the old value
        intf.wr_en = 1'b1; intf.rd_en = 1'b1; intf.addr = 3'd0; intf.wr_data = CW'(9);
        step("rw_same");
        check("rw_same.old", 32'(intf.rd_data), 32'd4);
        read_reg(0, "rw_new");
        check("rw_new.value", 32'(intf.rd_data), 32'd9);

        // Unmapped addresses and CTRL upper bits
        write_reg(6, 16'h1234, "unmapped");
        write_reg(7, 16'hbeef, "unmapped");
        read_reg(6, "unmapped_rd");
        check("unmapped_rd6", 32'(intf.rd_data), 32'd0);
        read_reg(7, "unmapped_rd");
        write_reg(1, 16'hfffe, "ctrl_bits");
        read_reg(1, "ctrl_bits_rd");
        check("ctrl_bits.off", 32'(intf.rd_data), 32'd0);
        write_reg(1, 16'hffff, "ctrl_bits");
        read_reg(1, "ctrl_bits_rd");
        check("ctrl_bits.on", 32'(intf.rd_data), 32'd1);

        // Randomized traffic against the model
        for (int r = 0; r < 6; r++) begin
            write_reg(0, $urandom_range(1, 12), "rnd_cfg");
            for (int c = 0; c < CH; c++) write_reg(2 + c, $urandom_range(0, 14), "rnd_cfg");
            write_reg(1, 1, "rnd_cfg");
            for (int k = 0; k < 60; k++) begin
                case ($urandom_range(0, 12))
                    0, 1, 2: read_reg(int'($urandom_range(0, 7)), "rnd_rd");
                    3:       write_reg(2 + int'($urandom_range(0, CH - 1)), $urandom_range(0, 14), "rnd_duty");
                    4:       write_reg(0, $urandom_range(0, 12), "rnd_period");
                    5:       write_reg(1, $urandom_range(0, 1), "rnd_en");
                    default: step("rnd_step");
                endcase
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/pwm.md
PWM -- requirements
Module: pwm

Interface
- REQ-001: pwm SHALL have exactly one port, `interf`, of interface type pwm_if; all signals below are members of pwm_if.
- REQ-002: Parameter CHANNELS, default 4, is the number of PWM outputs.
- REQ-003: Parameter CW, default 16, is the width of the counter, period and duty values.
- REQ-004: `clk`  input  1  single system clock; all logic is rising-edge.
- REQ-005: `resetn`  input  1  asynchronous, active-high reset (1 = reset asserted).
- REQ-006: `wr_en`  input  1  register write strobe, sampled on clk.
- REQ-007: `addr`  input  3  register address for both read and write.
- REQ-008: `wr_data`  input  CW  write data.
- REQ-009: `rd_en`  input  1  register read strobe.
- REQ-010: `rd_data`  output  CW  read data, registered.
- REQ-011: `rd_valid`  output  1  one-cycle pulse that qualifies rd_data.
- REQ-012: `pwm_out`  output  CHANNELS  PWM waveforms, registered.
- REQ-013: `period_tick`  output  1  one-cycle pulse at each period wrap.

Function
- REQ-014: Register map: addr 0 = PERIOD; addr 1 = CTRL (bit0 = ENABLE, other bits read 0); addr 2..2+CHANNELS-1 = DUTY[i]; all other addresses ignore writes and read 0.
- REQ-015: A write SHALL update the programmed register on the clk edge where wr_en=1.
- REQ-016: A read SHALL return the programmed (not shadow) value, with rd_data/rd_valid valid exactly 1 cycle after rd_en.
- REQ-017: wr_en and rd_en to the same address in the same cycle SHALL return the old value.
- REQ-018: The free-running counter cnt SHALL count 0..PERIOD_sh-1 and wrap to 0, where PERIOD_sh is the shadow period.
- REQ-019: period_tick SHALL be 1 in the cycle cnt wraps to 0.
- REQ-020: At every wrap, PERIOD_sh and DUTY_sh[i] SHALL load from the programmed registers; mid-period writes never alter the current period (glitch-free).
- REQ-021: pwm_out[i] SHALL be registered: high on the cycle after cnt < DUTY_sh[i], otherwise low, giving 1-cycle output latency.
- REQ-022: DUTY_sh[i] = 0 SHALL give a constant-low output.
- REQ-023: DUTY_sh[i] >= PERIOD_sh SHALL give a constant-high output (100%).
- REQ-024: PERIOD_sh = 0 SHALL hold cnt at 0, force all outputs low, and produce no period_tick; the shadows still reload every cycle so a new period is picked up.
- REQ-025: ENABLE = 0 SHALL hold cnt = 0, pwm_out = 0 and period_tick = 0, while shadows continuously track the programmed registers.
- REQ-026: On a 0->1 transition of ENABLE, counting SHALL start at cnt = 0 in the next cycle using the current programmed values.
- REQ-027: Clearing ENABLE mid-period SHALL drive pwm_out low on the next clock edge.
- REQ-028: Counter arithmetic is CW-bit unsigned; compare before increment; no overflow is possible because cnt < PERIOD_sh <= 2^CW-1.

Reset
- REQ-029: resetn = 1 SHALL immediately and asynchronously clear all registers, shadows, cnt, pwm_out, period_tick, rd_data and rd_valid to 0 (ENABLE = 0).
- REQ-030: After resetn deasserts, the block SHALL stay idle until software writes PERIOD, DUTY and ENABLE.
- REQ-031: Reset asserted mid-period SHALL abort the period with no residual pulse.

Structure
- REQ-032: Package pwm_pkg SHALL hold CW, CHANNELS, the address constants (ADDR_PERIOD, ADDR_CTRL, ADDR_DUTY0) and a typedef for the CW-bit count type.
- REQ-033: pwm_if SHALL declare clk and resetn as ports, all other signals as members, and modports dut and tb.
- REQ-034: Sub-module pwm_regs SHALL implement the register file and read path.
- REQ-035: pwm SHALL instantiate pwm_regs and contain the counter, shadows and comparators.

Verification
- REQ-036: PERIOD = 10, DUTY0 = 3, ENABLE = 1 -> pwm_out[0] high 3 of every 10 cycles, and period_tick every 10 cycles.
- REQ-037: DUTY1 = 0 and DUTY2 = 10 (= PERIOD) -> pwm_out[1] constant 0 and pwm_out[2] constant 1.
- REQ-038: While running at DUTY0 = 3, write DUTY0 = 7 at cnt = 5 -> current period keeps 3 high cycles; the next period has 7.
- REQ-039: Clear ENABLE at cnt = 2 -> pwm_out = 0 on the next edge and cnt held at 0; set ENABLE again -> restart at cnt = 0.
- REQ-040: Assert resetn mid-period -> all outputs 0 immediately, and reading PERIOD returns 0 with rd_valid 1 cycle after rd_en.
- REQ-041: PERIOD = 0 with ENABLE = 1 -> outputs 0 and no period_tick; then write PERIOD = 4 -> period_tick every 4 cycles.
